// File: rtl/maxnet_input_loader.sv
// Maxnet input loader: fetches a 4-word activation vector from data memory and
// holds it for the Maxnet datapath. Optional MAXNET_NEG_CLAMP_EN stores negative words as 0.
module maxnet_input_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] num1,
  output logic [DATA_W-1:0] num2,
  output logic [DATA_W-1:0] num3,
  output logic [DATA_W-1:0] num4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [1:0]        issue_cnt_reg;
  logic              issue_done_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              rd_pending_reg;
  logic [1:0]        cap_idx_reg;
  logic [DATA_W-1:0] num_reg [4];
  logic [DATA_W-1:0] cap_word;
  logic              issue_active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = FETCH;
      // Leave FETCH only once the data for the last issue has been captured.
      FETCH:   if (rd_pending_reg && (cap_idx_reg == 2'd3)) state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    issue_active = (state_reg == FETCH) && !issue_done_reg;
    mem_rd_en    = issue_active;
    out_valid    = (state_reg == HOLD);
    busy         = (state_reg != IDLE);
  end

  // Issue counter and address; the address stops at base+3 after the last issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt_reg  <= 2'd0;
      issue_done_reg <= 1'b0;
      addr_reg       <= '0;
      rd_pending_reg <= 1'b0;
      cap_idx_reg    <= 2'd0;
    end else begin
      rd_pending_reg <= issue_active;
      cap_idx_reg    <= issue_cnt_reg;
      if ((state_reg == IDLE) && start) begin
        addr_reg       <= base_addr;
        issue_cnt_reg  <= 2'd0;
        issue_done_reg <= 1'b0;
      end else if (issue_active) begin
        if (issue_cnt_reg == 2'd3) begin
          issue_done_reg <= 1'b1;
        end else begin
          issue_cnt_reg <= issue_cnt_reg + 2'd1;
          addr_reg      <= addr_reg + ADDR_W'(1);
        end
      end
    end
  end

  assign mem_rd_addr = addr_reg;

`ifdef MAXNET_NEG_CLAMP_EN
  assign cap_word = mem_rd_data[DATA_W-1] ? '0 : mem_rd_data;
`else
  assign cap_word = mem_rd_data;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_num
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          num_reg[gi] <= '0;
        else if (rd_pending_reg && (cap_idx_reg == 2'(gi)))
          num_reg[gi] <= cap_word;
      end
    end
  endgenerate

  assign num1 = num_reg[0];
  assign num2 = num_reg[1];
  assign num3 = num_reg[2];
  assign num4 = num_reg[3];

endmodule

// File: tb/tb_maxnet_input_loader.sv
// Directed bench for maxnet_input_loader with a 1-cycle-latency memory model.
module tb_maxnet_input_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic [31:0] num1, num2, num3, num4;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  logic [31:0] mem [256];
  int checks = 0;
  int errors = 0;

  maxnet_input_loader #(.DATA_W(32), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .num1(num1), .num2(num2), .num3(num3), .num4(num4),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  task automatic start_load(input logic [7:0] b);
    @(negedge clk); start = 1'b1; base_addr = b;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic handshake();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = 8'h00; out_ready = 1'b0; mem_rd_data = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_rd_en, out_valid, busy, mem_rd_addr} !== 11'd0 || {num1, num2, num3, num4} !== 128'd0) begin
      errors++;
      $display("FAIL reset_outputs en=%b valid=%b busy=%b addr=%h nums=%h %h %h %h required all 0",
               mem_rd_en, out_valid, busy, mem_rd_addr, num1, num2, num3, num4);
    end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_basic_load();
    logic [7:0] ea;
    mem[8'h10] = 32'd5; mem[8'h11] = 32'd9; mem[8'h12] = 32'd3; mem[8'h13] = 32'd7;
    start_load(8'h10);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      ea = 8'h10 + 8'((k > 4) ? 3 : k - 1);
      checks++;
      if (mem_rd_en !== (k <= 4) || mem_rd_addr !== ea) begin
        errors++;
        $display("FAIL basic_issue k=%0d en=%b addr=%h required en=%b addr=%h", k, mem_rd_en, mem_rd_addr, (k <= 4), ea);
      end
      checks++;
      if (out_valid !== (k == 6) || busy !== 1'b1) begin
        errors++;
        $display("FAIL basic_valid k=%0d valid=%b busy=%b required valid=%b busy=1", k, out_valid, busy, (k == 6));
      end
      if (k == 3) begin
        checks++;
        if (num1 !== 32'd5 || num2 !== 32'd0) begin
          errors++;
          $display("FAIL basic_partial num1=%0d num2=%0d required 5 0", num1, num2);
        end
      end
    end
    checks++;
    if (num1 !== 32'd5 || num2 !== 32'd9 || num3 !== 32'd3 || num4 !== 32'd7) begin
      errors++;
      $display("FAIL basic_vector got %0d %0d %0d %0d required 5 9 3 7", num1, num2, num3, num4);
    end
    $display("test_basic_load done");
  endtask

  task automatic test_hold();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || num1 !== 32'd5 || num2 !== 32'd9 || num3 !== 32'd3 || num4 !== 32'd7) begin
        errors++;
        $display("FAIL hold_stable c=%0d valid=%b got %0d %0d %0d %0d required 1 5 9 3 7", c, out_valid, num1, num2, num3, num4);
      end
    end
    handshake();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || mem_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL hold_release valid=%b busy=%b en=%b required 0 0 0", out_valid, busy, mem_rd_en);
    end
    $display("test_hold done");
  endtask

  task automatic test_wrap();
    logic [7:0] ea;
    mem[8'hFE] = 32'd11; mem[8'hFF] = 32'd22; mem[8'h00] = 32'd33; mem[8'h01] = 32'd44;
    out_ready = 1'b1;
    @(negedge clk); start = 1'b1; base_addr = 8'hFE;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        ea = 8'hFE + 8'(k - 1);
        checks++;
        if (mem_rd_en !== 1'b1 || mem_rd_addr !== ea) begin
          errors++;
          $display("FAIL wrap_addr k=%0d en=%b addr=%h required 1 %h", k, mem_rd_en, mem_rd_addr, ea);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b1 || num1 !== 32'd11 || num2 !== 32'd22 || num3 !== 32'd33 || num4 !== 32'd44) begin
      errors++;
      $display("FAIL wrap_vector valid=%b got %0d %0d %0d %0d required 1 11 22 33 44", out_valid, num1, num2, num3, num4);
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_release valid=%b busy=%b required 0 0", out_valid, busy);
    end
    $display("test_wrap done");
  endtask

  task automatic test_start_ignored();
    int pulses = 0;
    mem[8'h20] = 32'd1; mem[8'h21] = 32'd2; mem[8'h22] = 32'd3; mem[8'h23] = 32'd4;
    start_load(8'h20);
    start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_rd_en === 1'b1) pulses++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_hs_ignored valid=%b busy=%b required 0 0", out_valid, busy);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (mem_rd_en === 1'b1 || busy === 1'b1) pulses += 10;
    end
    checks++;
    if (pulses !== 4) begin
      errors++;
      $display("FAIL start_pulse_count got %0d required 4", pulses);
    end
    checks++;
    if (num1 !== 32'd1 || num2 !== 32'd2 || num3 !== 32'd3 || num4 !== 32'd4) begin
      errors++;
      $display("FAIL start_vector got %0d %0d %0d %0d required 1 2 3 4", num1, num2, num3, num4);
    end
    $display("test_start_ignored done");
  endtask

  task automatic test_reset_midfetch();
    mem[8'h30] = 32'hA; mem[8'h31] = 32'hB; mem[8'h32] = 32'hC; mem[8'h33] = 32'hD;
    start_load(8'h30);
    repeat (3) @(negedge clk);
    checks++;
    if (mem_rd_en !== 1'b1 || mem_rd_addr !== 8'h32) begin
      errors++;
      $display("FAIL midfetch_pre en=%b addr=%h required 1 32", mem_rd_en, mem_rd_addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_rd_en, out_valid, busy, mem_rd_addr} !== 11'd0 || {num1, num2, num3, num4} !== 128'd0) begin
      errors++;
      $display("FAIL midfetch_async en=%b valid=%b busy=%b addr=%h nums=%h %h %h %h required all 0",
               mem_rd_en, out_valid, busy, mem_rd_addr, num1, num2, num3, num4);
    end
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || num1 !== 32'd0 || mem_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL midfetch_idle busy=%b num1=%h en=%b required 0 0 0", busy, num1, mem_rd_en);
    end
    start_load(8'h30);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        checks++;
        if (mem_rd_en !== 1'b1 || mem_rd_addr !== 8'h30 + 8'(k - 1)) begin
          errors++;
          $display("FAIL midfetch_reload_addr k=%0d en=%b addr=%h required 1 %h", k, mem_rd_en, mem_rd_addr, 8'h30 + 8'(k - 1));
        end
      end
    end
    checks++;
    if (out_valid !== 1'b1 || num1 !== 32'hA || num2 !== 32'hB || num3 !== 32'hC || num4 !== 32'hD) begin
      errors++;
      $display("FAIL midfetch_reload valid=%b got %h %h %h %h required 1 a b c d", out_valid, num1, num2, num3, num4);
    end
    handshake();
    $display("test_reset_midfetch done");
  endtask

  task automatic test_clamp();
    logic [31:0] e1, e3;
`ifdef MAXNET_NEG_CLAMP_EN
    e1 = 32'h0; e3 = 32'h0;
`else
    e1 = 32'hFFFFFFFB; e3 = 32'hFFFFFFFF;
`endif
    mem[8'h40] = 32'hFFFFFFFB; mem[8'h41] = 32'd6; mem[8'h42] = 32'hFFFFFFFF; mem[8'h43] = 32'h7FFFFFFF;
    start_load(8'h40);
    repeat (6) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || num1 !== e1 || num2 !== 32'd6 || num3 !== e3 || num4 !== 32'h7FFFFFFF) begin
      errors++;
      $display("FAIL clamp_vector valid=%b got %h %h %h %h required 1 %h 00000006 %h 7fffffff",
               out_valid, num1, num2, num3, num4, e1, e3);
    end
    handshake();
    $display("test_clamp done");
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_hold();
    test_wrap();
    test_start_ignored();
    test_reset_midfetch();
    test_clamp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
